// File: rtl/wb_regfile_pkg.sv
// Shared register-mode encoding and helper for the Wishbone register file.
// Pure definitions; no logic, no latency.
package wb_regfile_pkg;

  localparam logic [1:0] MODE_CTL   = 2'd0;
  localparam logic [1:0] MODE_STAT  = 2'd1;
  localparam logic [1:0] MODE_PULSE = 2'd2;

  // Upper bound on NREG; masks are widened to this before lookup.
  localparam int MAX_REGS = 256;

  // Status wins over pulse when both mask bits are set.
  function automatic logic [1:0] reg_mode(input int k,
                                          input logic [MAX_REGS-1:0] ro_mask,
                                          input logic [MAX_REGS-1:0] pulse_mask);
    if (ro_mask[k])    return MODE_STAT;
    if (pulse_mask[k]) return MODE_PULSE;
    return MODE_CTL;
  endfunction

endpackage

// File: rtl/wb_reg_cell.sv
// One DW-bit register of the file: control, status or pulse behaviour by MODE.
// Write commits on the request edge; strobe and pulse data last exactly one cycle.
module wb_reg_cell
  import wb_regfile_pkg::*;
#(
  parameter int          DW      = 16,
  parameter logic [1:0]  MODE    = MODE_CTL,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  input  logic [DW-1:0] stat_dat,
  output logic [DW-1:0] reg_dat,
  output logic [DW-1:0] rd_dat,
  output logic          wr_strobe
);

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      reg_dat   <= (MODE == MODE_CTL) ? RST_VAL : '0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= wr_vld;
      case (MODE)
        MODE_CTL:   if (wr_vld) reg_dat <= wr_dat;
        MODE_PULSE: reg_dat <= wr_vld ? wr_dat : '0;
        default:    reg_dat <= '0;
      endcase
    end
  end

  // Read value seen by the bus: pulse registers always read back zero.
  assign rd_dat = (MODE == MODE_CTL)  ? reg_dat :
                  (MODE == MODE_STAT) ? stat_dat : '0;

endmodule

// File: rtl/wb_regfile_ctl.sv
// Parametrised Wishbone slave register file with control, status and pulse registers.
// Ack one cycle after request, never on consecutive cycles; stb held through ack is re-serviced after ack drops.
module wb_regfile_ctl
  import wb_regfile_pkg::*;
#(
  parameter int               DW         = 16,
  parameter int               ADRBITS    = 3,
  parameter int               NREG       = 8,
  parameter logic [NREG-1:0]    RO_MASK    = '0,
  parameter logic [NREG-1:0]    PULSE_MASK = '0,
  parameter logic [DW*NREG-1:0] RST_VAL    = '0
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [ADRBITS-1:0]   wb_adr,
  input  logic [DW-1:0]        wb_dat_i,
  output logic [DW-1:0]        wb_dat_o,
  output logic                 wb_ack,
  output logic [DW*NREG-1:0]   reg_o,
  input  logic [DW*NREG-1:0]   stat_i,
  output logic [NREG-1:0]      wr_strobe_o
);

  localparam logic [MAX_REGS-1:0] RO_EXT    = MAX_REGS'(RO_MASK);
  localparam logic [MAX_REGS-1:0] PULSE_EXT = MAX_REGS'(PULSE_MASK);

  logic            req_vld;
  logic [NREG-1:0] wr_hit;
  logic [DW-1:0]   rd_arr [NREG];
  logic [DW-1:0]   rd_sel;

  // Masking with wb_ack turns a held strobe into one request per ack.
  assign req_vld = wb_cyc & wb_stb & ~wb_ack;

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    assign wr_hit[k] = req_vld & wb_we & (wb_adr == ADRBITS'(k));

    wb_reg_cell #(
      .DW      (DW),
      .MODE    (reg_mode(k, RO_EXT, PULSE_EXT)),
      .RST_VAL (RST_VAL[k*DW +: DW])
    ) u_cell (
      .wb_clk    (wb_clk),
      .wb_rst_n  (wb_rst_n),
      .wr_vld    (wr_hit[k]),
      .wr_dat    (wb_dat_i),
      .stat_dat  (stat_i[k*DW +: DW]),
      .reg_dat   (reg_o[k*DW +: DW]),
      .rd_dat    (rd_arr[k]),
      .wr_strobe (wr_strobe_o[k])
    );
  end

  // Addresses at or beyond NREG match nothing and read as zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NREG; k++) begin
      if (wb_adr == ADRBITS'(k)) rd_sel = rd_arr[k];
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack <= req_vld;
      if (req_vld && !wb_we) wb_dat_o <= rd_sel;
    end
  end

endmodule
